// File: rtl/div_pkg.sv
// div_pkg: shared constants and state type for the divider sequencer.
// Rev 1.0
`default_nettype none
package div_pkg;
  localparam int WIDTH      = 32;
  localparam int DIV_CYCLES = 33;
  localparam int CNT_W      = 6;
  localparam logic [WIDTH-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage
`default_nettype wire

// File: rtl/div.sv
// div: 32-bit signed non-restoring divider stepped by an external count (0 load, 1..32 iterate).
// Rev 1.0
`default_nettype none
module div (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  input  logic [31:0] i_count,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);
  logic [31:0] r_q;
  logic [33:0] r_r;
  logic [31:0] r_d;
  logic        r_neg;

  logic        w_load;
  logic        w_iter;
  logic        w_last;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [33:0] w_shift;
  logic [33:0] w_dext;
  logic [33:0] w_rstep;
  logic [33:0] w_rfix;
  logic [31:0] w_qstep;

  always_comb begin
    w_load  = (i_count == 32'd0);
    w_last  = (i_count == 32'd32);
    w_iter  = (i_count != 32'd0) && (i_count <= 32'd32);
    w_abs_a = i_dividend[31] ? (32'd0 - i_dividend) : i_dividend;
    w_abs_b = i_divisor[31]  ? (32'd0 - i_divisor)  : i_divisor;
    w_shift = {r_r[32:0], r_q[31]};
    w_dext  = {2'b00, r_d};
    // Bit 33 is the partial-remainder sign: add back when negative, subtract otherwise.
    w_rstep = r_r[33] ? (w_shift + w_dext) : (w_shift - w_dext);
    w_qstep = {r_q[30:0], ~w_rstep[33]};
    w_rfix  = (w_last && w_rstep[33]) ? (w_rstep + w_dext) : w_rstep;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= '0;
      r_r   <= '0;
      r_d   <= '0;
      r_neg <= 1'b0;
    end else if (w_load) begin
      r_q   <= w_abs_a;
      r_r   <= '0;
      r_d   <= w_abs_b;
      r_neg <= i_dividend[31] ^ i_divisor[31];
    end else if (w_iter) begin
      r_q   <= w_qstep;
      r_r   <= w_rfix;
    end
  end

  assign o_quotient  = r_neg ? (32'd0 - r_q) : r_q;
  assign o_remainder = r_r[31:0];
endmodule
`default_nettype wire

// File: rtl/div_counter.sv
// div_counter: 6-bit iteration counter, zero-extended for the divider count input.
// Rev 1.0
`default_nettype none
module div_counter #(
  parameter int CW = 6,
  parameter int OW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic [OW-1:0] o_cnt_ext
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_cnt_ext = {{(OW-CW){1'b0}}, r_cnt};
endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
// div_ctrl: accepts a divide request, sequences div through its count range and registers the result.
// Rev 1.0
`default_nettype none
module div_ctrl
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_rem,
  output logic             data_exc
);
  state_t           r_state;
  logic [WIDTH-1:0] r_a_q;
  logic [WIDTH-1:0] r_b_q;
  logic             r_busy;
  logic             r_rdy;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_rem;
  logic             r_exc;

  logic [CNT_W-1:0] w_cnt;
  logic [WIDTH-1:0] w_count;
  logic             w_at_last;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_rem_signed;

  assign w_at_last    = (w_cnt == CNT_W'(DIV_CYCLES));
  assign w_cnt_en     = (r_state == RUN);
  // Count sits at 0 outside RUN so div keeps reloading the held operands.
  assign w_cnt_clr    = (r_state != RUN) || w_at_last;
  assign w_rem_signed = r_a_q[WIDTH-1] ? (ZERO_WORD - w_rem_mag) : w_rem_mag;

  div_counter #(
    .CW (CNT_W),
    .OW (WIDTH)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_cnt     (w_cnt),
    .o_cnt_ext (w_count)
  );

  div u_div (
    .clk         (clk),
    .reset       (reset),
    .i_dividend  (r_a_q),
    .i_divisor   (r_b_q),
    .i_count     (w_count),
    .o_quotient  (w_quot),
    .o_remainder (w_rem_mag)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_a_q    <= ZERO_WORD;
      r_b_q    <= ZERO_WORD;
      r_busy   <= 1'b0;
      r_rdy    <= 1'b0;
      r_result <= ZERO_WORD;
      r_rem    <= ZERO_WORD;
      r_exc    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rdy <= 1'b0;
          if (ctrl_div) begin
            r_a_q   <= operand_a;
            r_b_q   <= operand_b;
            r_busy  <= 1'b1;
            r_state <= (operand_b == ZERO_WORD) ? ZERO : RUN;
          end
        end
        RUN: begin
          if (w_at_last) begin
            r_result <= w_quot;
            r_rem    <= w_rem_signed;
            r_exc    <= 1'b0;
            r_busy   <= 1'b0;
            r_rdy    <= 1'b1;
            r_state  <= DONE;
          end
        end
        ZERO: begin
          r_result <= ZERO_WORD;
          r_rem    <= ZERO_WORD;
          r_exc    <= 1'b1;
          r_busy   <= 1'b0;
          r_rdy    <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_rdy   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign result_rdy  = r_rdy;
  assign data_result = r_result;
  assign data_rem    = r_rem;
  assign data_exc    = r_exc;
endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed self-checking bench for div_ctrl with a latency/arithmetic reference model.
// Rev 1.0
`default_nettype none
module tb_div_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_div = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy;
  logic        result_rdy;
  logic [31:0] data_result;
  logic [31:0] data_rem;
  logic        data_exc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .ctrl_div    (ctrl_div),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .busy        (busy),
    .result_rdy  (result_rdy),
    .data_result (data_result),
    .data_rem    (data_rem),
    .data_exc    (data_exc)
  );

  // Reference: a request occupies the unit for 34 edges (1 on divide-by-zero), then results appear.
  bit          m_pend = 1'b0;
  bit          m_rdy  = 1'b0;
  int          m_left = 0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_res = '0;
  logic [31:0] m_rem = '0;
  bit          m_exc = 1'b0;

  function automatic void model_calc(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r, output bit e);
    longint la;
    longint lb;
    longint lq;
    longint lr;
    if (b == 32'd0) begin
      q = '0; r = '0; e = 1'b1;
    end else begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      lq = la / lb;
      lr = la % lb;
      q = lq[31:0]; r = lr[31:0]; e = 1'b0;
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 1'b0; m_rdy = 1'b0; m_left = 0;
      m_res = '0; m_rem = '0; m_exc = 1'b0;
    end else if (m_rdy) begin
      m_rdy = 1'b0;
    end else if (m_pend) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        model_calc(m_a, m_b, m_res, m_rem, m_exc);
        m_pend = 1'b0;
        m_rdy  = 1'b1;
      end
    end else if (ctrl_div) begin
      m_pend = 1'b1;
      m_a    = operand_a;
      m_b    = operand_b;
      m_left = (operand_b == 32'd0) ? 1 : 34;
    end
  end

  always @(negedge clk) begin
    n_cmp++;
    if ({busy, result_rdy, data_exc, data_result, data_rem} !==
        {m_pend, m_rdy, m_exc, m_res, m_rem}) begin
      n_bad++;
      $display("FAIL cycle t=%0t got busy=%b rdy=%b exc=%b res=%h rem=%h want busy=%b rdy=%b exc=%b res=%h rem=%h",
               $time, busy, result_rdy, data_exc, data_result, data_rem,
               m_pend, m_rdy, m_exc, m_res, m_rem);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    ctrl_div  = 1'b1;
    operand_a = a;
    operand_b = b;
    @(negedge clk);
    ctrl_div  = 1'b0;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!result_rdy && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!result_rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rdy_timeout got no result_rdy want pulse within 100 cycles");
    end
  endtask

  task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] eq, input logic [31:0] er,
                         input logic ee);
    int lat;
    drive(a, b);
    wait_rdy(lat);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_res"}, data_result, eq);
    chk({nm, "_rem"}, data_rem, er);
    chk({nm, "_exc"}, {31'd0, data_exc}, {31'd0, ee});
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int pulses;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rdy",  {31'd0, result_rdy}, 32'd0);
    chk("reset_res",  data_result, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_div("t1_100_7",  32'd100,        32'd7,          34, 32'd14,        32'd2,        1'b0);
    run_div("t2_m100_7", 32'hFFFFFF9C,   32'd7,          34, 32'hFFFFFFF2,  32'hFFFFFFFE, 1'b0);
    run_div("t2_100_m7", 32'd100,        32'hFFFFFFF9,   34, 32'hFFFFFFF2,  32'd2,        1'b0);
    run_div("t3_5_0",    32'd5,          32'd0,          1,  32'd0,         32'd0,        1'b1);
    run_div("t4_min_m1", 32'h80000000,   32'hFFFFFFFF,   34, 32'h80000000,  32'd0,        1'b0);
    run_div("t4_max_1",  32'h7FFFFFFF,   32'd1,          34, 32'h7FFFFFFF,  32'd0,        1'b0);

    // Start request while busy must be dropped.
    drive(32'd100, 32'd7);
    repeat (10) @(negedge clk);
    drive(32'd9, 32'd3);
    wait_rdy(lat);
    chk("t5_ignored_lat", lat + 11, 34);
    chk("t5_ignored_res", data_result, 32'd14);
    chk("t5_ignored_rem", data_rem, 32'd2);
    // Request held through DONE: ignored there, accepted in the following IDLE cycle.
    ctrl_div  = 1'b1;
    operand_a = 32'd1;
    operand_b = 32'd1;
    @(negedge clk);
    drive(32'd9, 32'd3);
    wait_rdy(lat);
    chk("t5_b2b_lat", lat, 34);
    chk("t5_b2b_res", data_result, 32'd3);
    chk("t5_b2b_rem", data_rem, 32'd0);
    @(negedge clk);

    drive(32'd100, 32'd7);
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_res",  data_result, 32'd0);
    chk("t6_async_exc",  {31'd0, data_exc}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_rdy) pulses++;
    end
    chk("t6_no_rdy", pulses, 0);
    run_div("t6_81_9", 32'd81, 32'd9, 34, 32'd9, 32'd0, 1'b0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
